// File: rtl/fib_stream_checker.sv
// Consumer-side checker for a valid-qualified Fibonacci stream (seeds SEED_A, SEED_B,
// then the sum of the two previous terms modulo 2^W). It reports per-term match pulses,
// a sticky first-error capture, and a saturating count of correct terms.
module fib_stream_checker #(
  parameter int unsigned W      = 16,
  parameter int unsigned SEED_A = 1,
  parameter int unsigned SEED_B = 1,
  parameter int unsigned CW     = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_in_valid,
  input  logic [W-1:0]  i_in_data,
  output logic          o_match,
  output logic          o_err,
  output logic [W-1:0]  o_err_expected,
  output logic [W-1:0]  o_err_got,
  output logic [CW-1:0] o_err_index,
  output logic [CW-1:0] o_term_count,
  output logic          o_busy
);

  typedef enum logic [1:0] {StExp0, StExp1, StRun, StFail} state_e;

  localparam logic [W-1:0] SeedA = W'(SEED_A);
  localparam logic [W-1:0] SeedB = W'(SEED_B);

  state_e         r_state, w_state_next;
  logic [W-1:0]   r_prev1, w_prev1_next;
  logic [W-1:0]   r_prev2, w_prev2_next;
  logic           r_match, w_match_next;
  logic           r_err, w_err_next;
  logic [W-1:0]   r_err_expected, w_err_expected_next;
  logic [W-1:0]   r_err_got, w_err_got_next;
  logic [CW-1:0]  r_err_index, w_err_index_next;
  logic [CW-1:0]  r_term_count, w_term_count_next;
  logic [W-1:0]   w_expected;
  logic [CW-1:0]  w_count_inc;

  // Expected value of the next term; in RUN the carry out of the sum is dropped.
  always_comb begin
    w_expected = r_prev1 + r_prev2;
    unique case (r_state)
      StExp0:  w_expected = SeedA;
      StExp1:  w_expected = SeedB;
      default: w_expected = r_prev1 + r_prev2;
    endcase
  end

  // Count of correct terms holds at all-ones instead of wrapping.
  assign w_count_inc = (&r_term_count) ? r_term_count : r_term_count + CW'(1);

  // Next-state logic: clear beats a same-cycle sample; FAIL ignores samples.
  always_comb begin
    w_state_next        = r_state;
    w_prev1_next        = r_prev1;
    w_prev2_next        = r_prev2;
    w_match_next        = 1'b0;
    w_err_next          = r_err;
    w_err_expected_next = r_err_expected;
    w_err_got_next      = r_err_got;
    w_err_index_next    = r_err_index;
    w_term_count_next   = r_term_count;

    if (i_clear) begin
      w_state_next      = StExp0;
      w_prev1_next      = '0;
      w_prev2_next      = '0;
      w_term_count_next = '0;
    end else if (i_in_valid && (r_state != StFail)) begin
      if (i_in_data == w_expected) begin
        w_match_next      = 1'b1;
        w_term_count_next = w_count_inc;
        unique case (r_state)
          StExp0: begin
            w_state_next = StExp1;
            w_prev2_next = i_in_data;
          end
          StExp1: begin
            w_state_next = StRun;
            w_prev1_next = i_in_data;
          end
          default: begin
            w_prev2_next = r_prev1;
            w_prev1_next = i_in_data;
          end
        endcase
      end else begin
        w_state_next = StFail;
        // Only the first mismatch since reset is captured, even across clears.
        if (!r_err) begin
          w_err_next          = 1'b1;
          w_err_expected_next = w_expected;
          w_err_got_next      = i_in_data;
          w_err_index_next    = r_term_count;
        end
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= StExp0;
      r_prev1        <= '0;
      r_prev2        <= '0;
      r_match        <= 1'b0;
      r_err          <= 1'b0;
      r_err_expected <= '0;
      r_err_got      <= '0;
      r_err_index    <= '0;
      r_term_count   <= '0;
    end else begin
      r_state        <= w_state_next;
      r_prev1        <= w_prev1_next;
      r_prev2        <= w_prev2_next;
      r_match        <= w_match_next;
      r_err          <= w_err_next;
      r_err_expected <= w_err_expected_next;
      r_err_got      <= w_err_got_next;
      r_err_index    <= w_err_index_next;
      r_term_count   <= w_term_count_next;
    end
  end

  assign o_match        = r_match;
  assign o_err          = r_err;
  assign o_err_expected = r_err_expected;
  assign o_err_got      = r_err_got;
  assign o_err_index    = r_err_index;
  assign o_term_count   = r_term_count;
  assign o_busy         = (r_state == StExp1) || (r_state == StRun);

endmodule

// File: tb/tb_fib_stream_checker.sv
// Bench for fib_stream_checker: table-driven vectors, directed corner sequences and
// randomized traffic, all compared against a term-index model of the stream.
module tb_fib_stream_checker;

  localparam int NTab = 70000;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_clear;
  logic        i_in_valid;
  logic [15:0] i_in_data;
  logic        o_match;
  logic        o_err;
  logic [15:0] o_err_expected;
  logic [15:0] o_err_got;
  logic [15:0] o_err_index;
  logic [15:0] o_term_count;
  logic        o_busy;

  fib_stream_checker dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_clear        (i_clear),
    .i_in_valid     (i_in_valid),
    .i_in_data      (i_in_data),
    .o_match        (o_match),
    .o_err          (o_err),
    .o_err_expected (o_err_expected),
    .o_err_got      (o_err_got),
    .o_err_index    (o_err_index),
    .o_term_count   (o_term_count),
    .o_busy         (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference: the whole Fibonacci sequence mod 2^16, plus how far into it we are.
  logic [15:0] fib_tab [NTab];
  int          m_idx;
  bit          m_failed;
  bit          m_match;
  bit          m_err;
  logic [15:0] m_exp, m_got, m_index;

  typedef struct {
    bit          v;
    logic [15:0] d;
    bit          c;
    bit          e_match;
    logic [15:0] e_count;
    bit          e_err;
    bit          e_busy;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [15:0] sat(input int x);
    return (x > 65535) ? 16'hFFFF : 16'(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("match", 32'(o_match), 32'(m_match));
    chk("err", 32'(o_err), 32'(m_err));
    chk("err_expected", 32'(o_err_expected), 32'(m_exp));
    chk("err_got", 32'(o_err_got), 32'(m_got));
    chk("err_index", 32'(o_err_index), 32'(m_index));
    chk("term_count", 32'(o_term_count), 32'(sat(m_idx)));
    chk("busy", 32'(o_busy), 32'(!m_failed && m_idx >= 1));
  endtask

  task automatic model_reset();
    m_idx = 0; m_failed = 0; m_match = 0;
    m_err = 0; m_exp = '0; m_got = '0; m_index = '0;
  endtask

  // Apply one cycle of stimulus (called at a falling edge) and check at the next one.
  task automatic drive(input bit v, input logic [15:0] d, input bit c);
    if (c) begin
      m_idx = 0; m_failed = 0; m_match = 0;
    end else if (v && !m_failed) begin
      if (d == fib_tab[m_idx]) begin
        m_idx++;
        m_match = 1;
      end else begin
        m_failed = 1;
        m_match  = 0;
        if (!m_err) begin
          m_err = 1; m_exp = fib_tab[m_idx]; m_got = d; m_index = sat(m_idx);
        end
      end
    end else begin
      m_match = 0;
    end
    i_in_valid = v;
    i_in_data  = d;
    i_clear    = c;
    @(negedge i_clk);
    check_model();
  endtask

  task automatic do_reset();
    i_in_valid = 0; i_in_data = '0; i_clear = 0;
    i_rst_n = 1'b0;
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    fib_tab[0] = 16'd1;
    fib_tab[1] = 16'd1;
    for (int k = 2; k < NTab; k++) fib_tab[k] = fib_tab[k-1] + fib_tab[k-2];

    i_rst_n = 1'b0; i_clear = 0; i_in_valid = 0; i_in_data = '0;
    model_reset();
    @(negedge i_clk);
    chk("reset_match", 32'(o_match), 0);
    chk("reset_err", 32'(o_err), 0);
    chk("reset_count", 32'(o_term_count), 0);
    chk("reset_busy", 32'(o_busy), 0);
    chk("reset_err_index", 32'(o_err_index), 0);
    i_rst_n = 1'b1;

    // Correct stream 1,1,2,3,5,8 back-to-back, then a gap.
    vecs[0] = '{1, 16'd1, 0, 1, 16'd1, 0, 1};
    vecs[1] = '{1, 16'd1, 0, 1, 16'd2, 0, 1};
    vecs[2] = '{1, 16'd2, 0, 1, 16'd3, 0, 1};
    vecs[3] = '{1, 16'd3, 0, 1, 16'd4, 0, 1};
    vecs[4] = '{1, 16'd5, 0, 1, 16'd5, 0, 1};
    vecs[5] = '{1, 16'd8, 0, 1, 16'd6, 0, 1};
    vecs[6] = '{0, 16'd13, 0, 0, 16'd6, 0, 1};
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].c);
      chk($sformatf("vec%0d_match", i), 32'(o_match), 32'(vecs[i].e_match));
      chk($sformatf("vec%0d_count", i), 32'(o_term_count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d_err", i), 32'(o_err), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(vecs[i].e_busy));
    end

    // 1,1,2,4: mismatch on term 3, then samples are ignored.
    drive(0, '0, 1);
    drive(1, 16'd1, 0);
    drive(1, 16'd1, 0);
    drive(1, 16'd2, 0);
    drive(1, 16'd4, 0);
    chk("bad_match", 32'(o_match), 0);
    chk("bad_err", 32'(o_err), 1);
    chk("bad_exp", 32'(o_err_expected), 3);
    chk("bad_got", 32'(o_err_got), 4);
    chk("bad_index", 32'(o_err_index), 3);
    drive(1, 16'd7, 0);
    drive(1, 16'd3, 0);
    chk("fail_hold_match", 32'(o_match), 0);
    chk("fail_hold_count", 32'(o_term_count), 3);
    chk("fail_busy", 32'(o_busy), 0);

    // Full 25 terms with wrap-around at term 24.
    do_reset();
    for (int k = 0; k < 24; k++) drive(1, fib_tab[k], 0);
    drive(1, 16'd9489, 0);
    chk("wrap_match", 32'(o_match), 1);
    chk("wrap_err", 32'(o_err), 0);
    chk("wrap_count", 32'(o_term_count), 25);

    // Bad first sample; clear; a later good stream leaves captures intact.
    do_reset();
    drive(1, 16'd0, 0);
    chk("t0_err", 32'(o_err), 1);
    chk("t0_exp", 32'(o_err_expected), 1);
    chk("t0_got", 32'(o_err_got), 0);
    chk("t0_index", 32'(o_err_index), 0);
    drive(0, '0, 1);
    drive(1, 16'd1, 0);
    drive(1, 16'd1, 0);
    drive(1, 16'd2, 0);
    chk("t0_after_match", 32'(o_match), 1);
    chk("t0_after_count", 32'(o_term_count), 3);
    chk("t0_after_exp", 32'(o_err_expected), 1);
    drive(1, 16'd9, 0);
    chk("second_err_got", 32'(o_err_got), 0);
    chk("second_err_index", 32'(o_err_index), 0);

    // Gapped stream, then clear together with a valid sample.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, fib_tab[k], 0);
      for (int g = 0; g < 3; g++) drive(0, 16'hBEEF, 0);
    end
    chk("gap_count", 32'(o_term_count), 3);
    drive(1, 16'd3, 1);
    chk("clrv_match", 32'(o_match), 0);
    chk("clrv_count", 32'(o_term_count), 0);
    chk("clrv_busy", 32'(o_busy), 0);
    drive(1, 16'd1, 0);
    chk("clrv_seed_match", 32'(o_match), 1);

    // Asynchronous reset between clock edges.
    drive(1, 16'd1, 0);
    drive(1, 16'd2, 0);
    drive(1, 16'd3, 0);
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_match", 32'(o_match), 0);
    chk("arst_count", 32'(o_term_count), 0);
    chk("arst_busy", 32'(o_busy), 0);
    chk("arst_err", 32'(o_err), 0);
    i_in_valid = 0; i_clear = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    drive(1, 16'd1, 0);
    chk("arst_after_match", 32'(o_match), 1);
    chk("arst_after_count", 32'(o_term_count), 1);

    // Saturation of the term counter; checking continues.
    drive(0, '0, 1);
    for (int k = 0; k < 65540; k++) drive(1, fib_tab[k], 0);
    chk("sat_count", 32'(o_term_count), 32'hFFFF);
    chk("sat_match", 32'(o_match), 1);
    drive(1, fib_tab[65540] + 16'd1, 0);
    chk("sat_err_index", 32'(o_err_index), 32'hFFFF);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      bit          c, v;
      logic [15:0] d;
      c = ($urandom_range(0, 29) == 0) || (m_idx > 150);
      v = ($urandom_range(0, 9) < 7);
      d = ($urandom_range(0, 24) == 0) ? 16'($urandom) : fib_tab[m_idx];
      drive(v, d, c);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fib_stream_checker.md
Name: fib_stream_checker

Overview:
- Consumer-side checker for the 16-bit Fibonacci stream produced by the team's generator blocks: seeds 1, 1, then each term is the sum of the previous two, modulo 2^W.
- Samples a valid-qualified data stream and checks every term against a locally computed expectation.
- Reports per-term match pulses, a sticky error with capture registers, and a term count.
- Sits on the generator's output bus in self-test and demo builds.

Parameters:
- W, 16, data width; all arithmetic is modulo 2^W.
- SEED_A, 1, required value of term 0.
- SEED_B, 1, required value of term 1.
- CW, 16, width of term counter and error index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous restart to the seed-expect state; does not reset the error captures.
- in_valid  input  1  in_data holds a term this cycle.
- in_data  input  W  term value.
- match  output  1  one-cycle pulse; the previously accepted term was correct.
- err  output  1  sticky mismatch flag.
- err_expected  output  W  expected value at the first mismatch.
- err_got  output  W  received value at the first mismatch.
- err_index  output  CW  term index of the first mismatch.
- term_count  output  CW  number of correct terms accepted; saturates at 2^CW-1.
- busy  output  1  state is EXP1 or RUN.

Behaviour:
- rst low (async): state=EXP0, prev1=prev2=0, match=0, err=0, err_expected=0, err_got=0, err_index=0, term_count=0, busy=0.
- All outputs are registered. A sample is accepted on a rising edge with in_valid=1. match is asserted for exactly the following cycle.
- in_valid=0 cycles are gaps: no state change, match=0. Gaps of any length are legal anywhere.
- Expected value, by state:
  - EXP0: SEED_A.
  - EXP1: SEED_B.
  - RUN: (prev1+prev2) mod 2^W. The carry is discarded, so wrap-around is correct behaviour, not an error.
- Transitions on an accepted sample:
  - EXP0, data==SEED_A: go to EXP1; prev2<=data; match; term_count+1.
  - EXP1, data==SEED_B: go to RUN; prev1<=data; match; term_count+1.
  - RUN, data==expected: stay in RUN; prev2<=prev1, prev1<=data; match; term_count+1.
  - Any state, data!=expected: go to FAIL. If err was 0: err<=1, err_expected<=expected, err_got<=data, err_index<=term_count. match=0; term_count is unchanged.
  - FAIL: samples are ignored; the state is held until clear or rst.
- clear=1: state<=EXP0, prev1=prev2=0, term_count<=0, match<=0. err and the capture registers are retained; they are cleared only by rst.
- clear and in_valid in the same cycle: clear wins and the sample is dropped.
- First error wins: the capture registers never update while err=1, including after a clear and a later mismatch.
- term_count saturates at all-ones and never wraps. Checking continues normally while saturated.
- rst asserted mid-run: immediate return to the reset values, regardless of clk.

Test Plan:
- Reset, then stream 1,1,2,3,5,8 with in_valid held high -> six match pulses, each one cycle after its sample; term_count=6; err=0; busy=1.
- Stream 1,1,2,4 -> match for the first three terms only; then err=1, err_expected=3, err_got=4, err_index=3; later samples produce no match and leave term_count=3.
- Stream the full 25 correct terms, wrapping: term 23=46368, term 24=(28657+46368) mod 65536=9489 -> match on term 24, err=0, term_count=25.
- First sample 0 -> err=1, err_expected=1, err_got=0, err_index=0, state FAIL. Pulse clear, then stream 1,1,2 -> three matches; err stays 1 with its captures unchanged.
- Stream 1,1,2 with 3-cycle gaps between samples, then assert clear and in_valid with value 3 in the same cycle -> no match for that sample; term_count=0; state EXP0.
- Stream 1,1,2,3, then drop rst low between clock edges -> all outputs read 0 before the next edge; after release, stream 1 -> one match, term_count=1.
